network_depacketizer: RTL

- Sits directly downstream of the network ejector; consumes its packed valid/ready flit stream.
- Splits each packet into a registered header channel and a payload stream with an end-of-packet marker.
- Enforces flit-type sequencing, bounds packet length, and reports protocol errors.
- Feeds unit-side logic that needs the header fields separately from the payload.

---
 rtl/network_depacketizer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/network_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module   : network_depacketizer
//  Purpose  : Splits the packed flit stream leaving the network ejector into
//             a registered header channel and a payload stream with an
//             end-of-packet marker. Checks flit-type sequencing, bounds the
//             packet length, and reports protocol errors.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i                 clock
//    rst_i                 asynchronous active-high reset
//    valid_i / ready_o     ejected flit handshake
//    data_i                packed flit {vn, broadcast, type, flit}, flit in LSBs
//    header_valid_o        header slot occupied
//    header_ready_i        consumer takes header
//    header_flit_o         header flit body
//    header_broadcast_o    header broadcast field
//    header_vn_o           header virtual network id
//    header_has_payload_o  1 for header, 0 for header_tail
//    payload_valid_o       payload flit valid
//    payload_ready_i       payload consumer ready
//    payload_data_o        payload flit body
//    payload_last_o        final flit of packet
//    protocol_error_o      one-cycle error pulse
//    error_count_o         saturating error count
// ============================================================================
module network_depacketizer #(
    parameter int NetworkIfFlitWidth             = 64,
    parameter int NetworkIfFlitTypeWidth         = 2,
    parameter int NetworkIfBroadcastWidth        = 1,
    parameter int NetworkIfVirtualNetworkIdWidth = 2,
    parameter int MaxPayloadFlits                = 16,
    parameter int ErrorCountWidth                = 16,
    localparam int DataWidth = NetworkIfVirtualNetworkIdWidth + NetworkIfBroadcastWidth
                             + NetworkIfFlitTypeWidth + NetworkIfFlitWidth
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      valid_i,
    output logic                                      ready_o,
    input  logic [DataWidth-1:0]                      data_i,
    output logic                                      header_valid_o,
    input  logic                                      header_ready_i,
    output logic [NetworkIfFlitWidth-1:0]             header_flit_o,
    output logic [NetworkIfBroadcastWidth-1:0]        header_broadcast_o,
    output logic [NetworkIfVirtualNetworkIdWidth-1:0] header_vn_o,
    output logic                                      header_has_payload_o,
    output logic                                      payload_valid_o,
    input  logic                                      payload_ready_i,
    output logic [NetworkIfFlitWidth-1:0]             payload_data_o,
    output logic                                      payload_last_o,
    output logic                                      protocol_error_o,
    output logic [ErrorCountWidth-1:0]                error_count_o
);

    localparam int FW = NetworkIfFlitWidth;
    localparam int TW = NetworkIfFlitTypeWidth;
    localparam int BW = NetworkIfBroadcastWidth;
    localparam int VW = NetworkIfVirtualNetworkIdWidth;

    // Counter must hold values 0..MaxPayloadFlits-1; the +1 keeps the width
    // non-zero when MaxPayloadFlits is 1.
    localparam int CntWidth = $clog2(MaxPayloadFlits + 1);

    // Flit type encodings shared with the network interface (net_common.h).
    localparam logic [TW-1:0] c_type_header      = TW'(0);
    localparam logic [TW-1:0] c_type_payload     = TW'(1);
    localparam logic [TW-1:0] c_type_tail        = TW'(2);
    localparam logic [TW-1:0] c_type_header_tail = TW'(3);

    localparam logic [CntWidth-1:0]        c_cnt_last = CntWidth'(MaxPayloadFlits - 1);
    localparam logic [ErrorCountWidth-1:0] c_err_max  = {ErrorCountWidth{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [CntWidth-1:0]   r_cnt;
    logic [VW-1:0]         r_pkt_vn;

    logic                  r_header_valid;
    logic [FW-1:0]         r_header_flit;
    logic [BW-1:0]         r_header_bcast;
    logic [VW-1:0]         r_header_vn;
    logic                  r_header_has_payload;

    logic                  r_payload_valid;
    logic [FW-1:0]         r_payload_data;
    logic                  r_payload_last;

    logic                  r_error;
    logic [ErrorCountWidth-1:0] r_err_count;

    // ------------------------------------------------------------------------
    // Input field decode
    // ------------------------------------------------------------------------
    logic [FW-1:0] w_flit;
    logic [TW-1:0] w_type;
    logic [BW-1:0] w_bcast;
    logic [VW-1:0] w_vn;
    logic          w_is_head;
    logic          w_is_body;
    logic          w_slot_free;
    logic          w_payload_free;
    logic          w_ready;
    logic          w_accept;
    logic          w_flit_error;

    assign w_flit  = data_i[FW-1:0];
    assign w_type  = data_i[FW +: TW];
    assign w_bcast = data_i[FW+TW +: BW];
    assign w_vn    = data_i[FW+TW+BW +: VW];

    assign w_is_head = (w_type == c_type_header) || (w_type == c_type_header_tail);
    assign w_is_body = (w_type == c_type_payload) || (w_type == c_type_tail);

    // A slot draining this cycle counts as free so headers stream at full rate.
    assign w_slot_free    = !r_header_valid  || header_ready_i;
    assign w_payload_free = !r_payload_valid || payload_ready_i;

    // Ready is a function of state, register occupancy, consumer readies and
    // the flit type on data_i, never of valid_i. Flits that will be dropped as
    // errors are always accepted so a misbehaving source cannot wedge the link.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:    w_ready = w_is_head ? w_slot_free : 1'b1;
            ST_PAYLOAD: w_ready = w_is_body ? w_payload_free : 1'b1;
            default:    w_ready = 1'b0;
        endcase
    end

    assign w_accept = valid_i && w_ready;

    // One error at most per accepted flit; the checks are ordered so that a
    // flit breaking several rules is still counted once.
    always_comb begin
        w_flit_error = 1'b0;
        if (w_accept) begin
            if (r_state == ST_IDLE) begin
                w_flit_error = !w_is_head;
            end else if (!w_is_body) begin
                w_flit_error = 1'b1;
            end else if (w_vn != r_pkt_vn) begin
                w_flit_error = 1'b1;
            end else if ((w_type == c_type_payload) && (r_cnt == c_cnt_last)) begin
                w_flit_error = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencing FSM with registered header slot, payload stage and errors
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state              <= ST_IDLE;
            r_cnt                <= '0;
            r_pkt_vn             <= '0;
            r_header_valid       <= 1'b0;
            r_header_flit        <= '0;
            r_header_bcast       <= '0;
            r_header_vn          <= '0;
            r_header_has_payload <= 1'b0;
            r_payload_valid      <= 1'b0;
            r_payload_data       <= '0;
            r_payload_last       <= 1'b0;
            r_error              <= 1'b0;
            r_err_count          <= '0;
        end else begin
            r_error <= w_flit_error;
            if (w_flit_error && (r_err_count != c_err_max)) begin
                r_err_count <= r_err_count + ErrorCountWidth'(1);
            end

            // Drains; a load below in the same cycle takes precedence.
            if (r_header_valid && header_ready_i) begin
                r_header_valid <= 1'b0;
            end
            if (payload_ready_i) begin
                r_payload_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_head) begin
                        r_header_valid       <= 1'b1;
                        r_header_flit        <= w_flit;
                        r_header_bcast       <= w_bcast;
                        r_header_vn          <= w_vn;
                        r_header_has_payload <= (w_type == c_type_header);
                        if (w_type == c_type_header) begin
                            r_state  <= ST_PAYLOAD;
                            r_cnt    <= '0;
                            r_pkt_vn <= w_vn;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // VN mismatches are still forwarded; only the error fires.
                    if (w_accept && w_is_body) begin
                        r_payload_valid <= 1'b1;
                        r_payload_data  <= w_flit;
                        if ((w_type == c_type_tail) || (r_cnt == c_cnt_last)) begin
                            // Either a proper tail or a forced truncation at the
                            // length limit; both close the packet here.
                            r_payload_last <= 1'b1;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_payload_last <= 1'b0;
                            r_cnt          <= r_cnt + CntWidth'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready_o              = w_ready;
    assign header_valid_o       = r_header_valid;
    assign header_flit_o        = r_header_flit;
    assign header_broadcast_o   = r_header_bcast;
    assign header_vn_o          = r_header_vn;
    assign header_has_payload_o = r_header_has_payload;
    assign payload_valid_o      = r_payload_valid;
    assign payload_data_o       = r_payload_data;
    assign payload_last_o       = r_payload_last;
    assign protocol_error_o     = r_error;
    assign error_count_o        = r_err_count;

endmodule
`default_nettype wire
